// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with single-line refill
module icache_direct #(
  parameter int CPU_ADDR_BITS = 32,
  parameter int FETCH_WIDTH   = 2,
  parameter int LINE_BYTES    = 16,
  parameter int NUM_SETS      = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         icache_inv,
  input  logic [CPU_ADDR_BITS-1:0]     icache_addr,
  input  logic                         icache_re,
  output logic [FETCH_WIDTH*32-1:0]    icache_dout,
  output logic                         icache_dout_val,
  output logic                         icache_stall,
  output logic                         mem_req_val,
  input  logic                         mem_req_rdy,
  output logic [CPU_ADDR_BITS-1:0]     mem_req_addr,
  input  logic                         mem_resp_val,
  input  logic [LINE_BYTES*8-1:0]      mem_resp_data
);

  localparam int OFF_BITS   = $clog2(LINE_BYTES);
  localparam int IDX_BITS   = $clog2(NUM_SETS);
  localparam int TAG_BITS   = CPU_ADDR_BITS - OFF_BITS - IDX_BITS;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int PAIR_W     = FETCH_WIDTH * 32;
  localparam int PAIR_BYTES = 4 * FETCH_WIDTH;
  // Offset bits that pick the pair within a line; bits below select bytes inside a pair.
  localparam logic [OFF_BITS-1:0] CHUNK_MASK = OFF_BITS'(LINE_BYTES - PAIR_BYTES);

  typedef enum logic [1:0] {LOOKUP, MISS_REQ, MISS_WAIT, REPLAY} state_t;
  state_t state, state_nxt;

  logic [LINE_W-1:0]        data_mem [NUM_SETS];
  logic [TAG_BITS-1:0]      tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]        data_rd;
  logic [TAG_BITS-1:0]      tag_rd;
  logic [NUM_SETS-1:0]      valid;
  logic [CPU_ADDR_BITS-1:0] lat_addr;
  logic                     req_pend;
  logic                     flushed;
  logic                     inv_pend;

  logic [TAG_BITS-1:0] lat_tag;
  logic [IDX_BITS-1:0] lat_idx;
  logic [IDX_BITS-1:0] req_idx;
  logic [IDX_BITS-1:0] rd_idx;
  logic [OFF_BITS-1:0] chunk_off;
  logic hit, miss, accept, rd_en, fill;

  assign lat_tag   = lat_addr[CPU_ADDR_BITS-1 -: TAG_BITS];
  assign lat_idx   = lat_addr[OFF_BITS +: IDX_BITS];
  assign req_idx   = icache_addr[OFF_BITS +: IDX_BITS];
  assign chunk_off = lat_addr[OFF_BITS-1:0] & CHUNK_MASK;

  assign icache_dout  = PAIR_W'(data_rd >> {chunk_off, 3'b000});
  assign mem_req_addr = {lat_addr[CPU_ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) state <= LOOKUP;
    else     state <= state_nxt;
  end

  always_comb begin
    hit             = req_pend && valid[lat_idx] && (tag_rd == lat_tag);
    miss            = req_pend && !hit;
    icache_stall    = (state != LOOKUP) || miss;
    accept          = (state == LOOKUP) && icache_re && !icache_stall;
    icache_dout_val = (state == LOOKUP) && hit && !flush;
    mem_req_val     = (state == MISS_REQ);
    fill            = (state == MISS_WAIT) && mem_resp_val && !rst;
    rd_en           = accept || (state == REPLAY);
    rd_idx          = accept ? req_idx : lat_idx;
    state_nxt       = state;
    case (state)
      LOOKUP:    if (miss) state_nxt = MISS_REQ;
      MISS_REQ:  if (mem_req_rdy) state_nxt = MISS_WAIT;
      // A flush seen at any point of the miss skips the replay.
      MISS_WAIT: if (fill) state_nxt = (flushed || flush) ? LOOKUP : REPLAY;
      REPLAY:    state_nxt = LOOKUP;
      default:   state_nxt = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[lat_idx] <= mem_resp_data;
      tag_mem[lat_idx]  <= lat_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd <= '0;
      tag_rd  <= '0;
    end else if (rd_en) begin
      data_rd <= data_mem[rd_idx];
      tag_rd  <= tag_mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pend <= 1'b0;
      lat_addr <= '0;
      flushed  <= 1'b0;
      inv_pend <= 1'b0;
      valid    <= '0;
    end else begin
      req_pend <= rd_en;
      if (accept) lat_addr <= icache_addr;
      if (state == LOOKUP) flushed <= miss && flush;
      else if (flush)      flushed <= 1'b1;
      // Invalidation waits for LOOKUP so it also wipes a line refilled mid-miss.
      if ((state == LOOKUP) && (icache_inv || inv_pend)) begin
        valid    <= '0;
        inv_pend <= 1'b0;
      end else begin
        if (icache_inv) inv_pend <= 1'b1;
        if (fill) valid[lat_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - randomized self-checking bench for icache_direct
module tb_icache_direct;
  localparam int NS = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         icache_inv = 1'b0;
  logic [31:0]  icache_addr = '0;
  logic         icache_re = 1'b0;
  logic [63:0]  icache_dout;
  logic         icache_dout_val;
  logic         icache_stall;
  logic         mem_req_val;
  logic         mem_req_rdy = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_val = 1'b0;
  logic [127:0] mem_resp_data = '0;

  int checks = 0;
  int errors = 0;

  bit          m_valid [NS];
  logic [21:0] m_tag   [NS];

  icache_direct #(
    .CPU_ADDR_BITS(32), .FETCH_WIDTH(2), .LINE_BYTES(16), .NUM_SETS(NS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .icache_inv(icache_inv),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .icache_dout_val(icache_dout_val), .icache_stall(icache_stall),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] d;
    logic [31:0]  base;
    base = a & ~32'hF;
    for (int w = 0; w < 4; w++) d[32*w +: 32] = mem_word(base + 32'(4 * w));
    return d;
  endfunction

  function automatic logic [63:0] exp_pair(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h7;
    return {mem_word(base + 32'd4), mem_word(base)};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_val"},   icache_dout_val, 0);
    check({tag, "_stall"}, icache_stall, 0);
    check({tag, "_mreq"},  mem_req_val, 0);
    check({tag, "_maddr"}, mem_req_addr, 0);
    check({tag, "_dout"},  icache_dout, 0);
  endtask

  // Entered at the negedge of the cycle where the miss became visible.
  task automatic service_miss(input logic [31:0] a, input int hold, input int lat,
                              input bit do_flush, input bit do_inv);
    int n = 0;
    while (!mem_req_val && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_val) begin
      check("req_timeout", 0, 1);
      return;
    end
    check("req_addr", mem_req_addr, a & ~32'hF);
    repeat (hold) begin
      @(negedge clk);
      check("bp_val", mem_req_val, 1);
      check("bp_addr", mem_req_addr, a & ~32'hF);
      check("bp_stall", icache_stall, 1);
    end
    mem_req_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_rdy = 1'b0;
    check("req_once", mem_req_val, 0);
    flush = do_flush;
    icache_inv = do_inv;
    repeat (lat) begin
      @(negedge clk);
      flush = 1'b0;
      icache_inv = 1'b0;
      check("wait_stall", icache_stall, 1);
    end
    mem_resp_data = line_of(a);
    mem_resp_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_resp_val = 1'b0;
    flush = 1'b0;
    icache_inv = 1'b0;
    m_valid[a[9:4]] = 1'b1;
    m_tag[a[9:4]] = a[31:10];
    if (do_flush) begin
      check("flush_val", icache_dout_val, 0);
      check("flush_stall", icache_stall, 0);
    end else begin
      check("replay_stall", icache_stall, 1);
      @(posedge clk);
      @(negedge clk);
      check("replay_val", icache_dout_val, 1);
      check("replay_data", icache_dout, exp_pair(a));
      check("replay_stall_done", icache_stall, 0);
    end
    if (do_inv) model_clear();
  endtask

  task automatic fetch(input logic [31:0] a, input int hold, input int lat,
                       input bit do_flush, input bit do_inv);
    bit exp_hit;
    exp_hit = model_hit(a);
    icache_addr = a;
    icache_re = 1'b1;
    @(posedge clk);
    @(negedge clk);
    icache_re = 1'b0;
    if (exp_hit) begin
      check("hit_val", icache_dout_val, 1);
      check("hit_data", icache_dout, exp_pair(a));
      check("hit_stall", icache_stall, 0);
    end else begin
      check("miss_stall", icache_stall, 1);
      check("miss_val", icache_dout_val, 0);
      service_miss(a, hold, lat, do_flush, do_inv);
    end
  endtask

  task automatic inv_pulse();
    icache_inv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    icache_inv = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] sa [3];
    logic [31:0] a;
    int r;
    int n;
    sa[0] = 32'h0; sa[1] = 32'h8; sa[2] = 32'h10;
    model_clear();

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    fetch(32'h0, 0, 1, 0, 0);
    fetch(32'h10, 0, 0, 0, 0);

    icache_addr = sa[0];
    icache_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stream_val", icache_dout_val, 1);
      check("stream_data", icache_dout, exp_pair(sa[i]));
      check("stream_stall", icache_stall, 0);
      if (i < 2) icache_addr = sa[i+1];
      else       icache_re = 1'b0;
    end

    fetch(32'h400, 1, 1, 0, 0);
    fetch(32'h0, 0, 2, 0, 0);

    fetch(32'h1234, 5, 2, 0, 0);

    fetch(32'h2040, 1, 3, 1, 0);
    fetch(32'h2044, 0, 0, 0, 0);

    inv_pulse();
    fetch(32'h0, 0, 0, 0, 0);
    fetch(32'h1238, 0, 1, 0, 0);

    fetch(32'h3000, 0, 2, 0, 1);
    fetch(32'h3004, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        inv_pulse();
      end else if (r == 1) begin
        mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_resp_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_resp_val = 1'b0;
      end else begin
        a = ($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 10) |
            ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
        fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
    end

    a = 32'h7FFF_0550;
    m_valid[a[9:4]] = 1'b0;
    icache_addr = a;
    icache_re = 1'b1;
    @(posedge clk);
    @(negedge clk);
    icache_re = 1'b0;
    check("rst_miss_stall", icache_stall, 1);
    n = 0;
    while (!mem_req_val && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", mem_req_val, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    model_clear();
    mem_resp_data = line_of(a);
    mem_resp_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_resp_val = 1'b0;
    check("late_resp_stall", icache_stall, 0);
    fetch(a, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
